seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Parametrised, multi-cycle shift-add multiplier. Successor to the fixed 3-bit combinational multipliers.
- Accepts one operand pair per start/done transaction.
- Produces a full-width 2*WIDTH-bit product in unsigned or two's-complement signed mode.
- Sits beside the datapath adders as a small-area arithmetic unit for iterative datapaths; trades latency for one WIDTH-bit adder instead of a WIDTH x WIDTH array.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); product is 2*WIDTH bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request pulse; sampled on rising clk edge.
- signed_mode  input  1  1 = operands and product are two's complement; 0 = unsigned. Sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while a multiplication is in progress (RUN or FIN).
- done  output  1  one-cycle pulse; product valid and newly updated.
- p  output  2*WIDTH  product register; holds last result until the next result is written.

Behaviour:
- Reset (rst high, asynchronous):
  - state=IDLE; busy=0, done=0, p=0.
  - Internal accumulator, operand registers and counter cleared.
  - Reset asserted mid-operation aborts the operation with no done pulse.
  - After rst deasserts, the block is ready to accept start on the next edge.
- States: IDLE, RUN, FIN.
- IDLE, or any cycle with done=1:
  - start=1 at edge k latches the operands.
  - In signed mode, the magnitudes |a| and |b| are latched as WIDTH-bit unsigned values (|-2^(WIDTH-1)| = 2^(WIDTH-1) fits unsigned).
  - neg = signed_mode & (a[MSB] ^ b[MSB]) is latched.
  - acc=0, count=0; go to RUN; busy=1 from edge k.
- RUN, one iteration per edge:
  - If multiplier LSB = 1, add the multiplicand into the upper half of acc (WIDTH+1-bit add, carry kept).
  - Then shift {carry, acc} right by one; multiplier register shifts right by one.
  - count increments.
  - After exactly WIDTH iterations (edges k+1..k+WIDTH), go to FIN.
- FIN (edge k+WIDTH+1):
  - p <= neg ? (~acc + 1) : acc, truncated to 2*WIDTH bits.
  - done=1 for exactly that one cycle; busy=0; return to IDLE.
- Latency: done is high in the cycle following edge k+WIDTH+1, i.e. WIDTH+1 edges after the start edge.
- start while busy=1 is ignored: no queueing, no effect on the current operation, operands not resampled.
- start in the cycle done=1 is accepted (back-to-back). Throughput is one result per WIDTH+1 cycles.
- p changes only at FIN or reset. It is stable in IDLE and during RUN (still shows the previous result).
- Zero operand: the full WIDTH iterations still run; latency is constant and data-independent.
- Signed product range: -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2) fits in 2*WIDTH bits signed. No overflow possible in either mode.
- X on a/b/signed_mode when start=0 has no effect.

Test Plan:
1. WIDTH=3, unsigned, a=3, b=7, one-cycle start -> busy high for 4 cycles; done pulses once 4 edges after start; p=6'd21 (010101); p stays 21 afterwards.
2. WIDTH=8, signed, a=-128 (8'h80), b=-128 -> p=16'h4000. Then a=-5, b=7 -> p=16'hFFDD (-35). Then a=127, b=-1 -> p=16'hFF81.
3. WIDTH=8, unsigned, a=255, b=255 -> p=16'hFE01. Then a=0, b=200 -> p=0, still with 9-cycle latency.
4. WIDTH=8: start a=12, b=10; pulse start again mid-RUN with a=1, b=1 -> the second start is ignored, a single done, p=120. Then start asserted in the done cycle with a=6, b=7 -> accepted, next done 9 edges later with p=42.
5. WIDTH=8: start a=9, b=9; assert rst asynchronously (between clock edges) at iteration 4 -> p=0, busy=0, done=0 immediately; no done pulse follows. After release, a=9, b=9 -> p=81.
6. WIDTH=4, exhaustive: all 256 unsigned and 256 signed operand pairs, back-to-back starts -> each p equals the reference product a*b (sign-extended operands in signed mode); exactly one done per start.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier producing a 2*WIDTH-bit
// product over WIDTH+1 clock cycles, in unsigned or two's-complement mode.
// Signed operands are reduced to magnitudes up front so the datapath only ever
// performs unsigned shift-add; the sign is reapplied once when the product is
// written.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_count;
  logic                 r_neg;

  logic [WIDTH-1:0]     w_absA;
  logic [WIDTH-1:0]     w_absB;
  logic                 w_neg;
  logic [WIDTH:0]       w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_result;

  // Operand magnitudes; the most negative value maps onto 2^(WIDTH-1), which
  // still fits when read as unsigned.
  assign w_absA = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign w_absB = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign w_neg  = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);

  // One partial-product step: the multiplicand is added into the upper half
  // of the accumulator when the current multiplier bit is set. The carry is
  // kept so that the right shift that follows loses nothing.
  assign w_addend = r_mplier[0] ? {1'b0, r_mcand} : '0;
  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;

  // Reapply the sign to the unsigned magnitude product.
  assign w_result = r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      p        <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= w_absA;
            r_mplier <= w_absB;
            r_neg    <= w_neg;
            r_acc    <= '0;
            r_count  <= '0;
            busy     <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1)) begin
            r_state <= FIN;
          end
        end
        FIN: begin
          p       <= w_result;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed checks of seq_multiplier at WIDTH=3, 8 and 4,
// covering latency, busy/done timing, signed corner cases, ignored starts,
// back-to-back starts, asynchronous abort and an exhaustive 4-bit sweep.
module tb_seq_multiplier;

  logic clk;
  logic rst;

  logic       start3, sm3, busy3, done3;
  logic [2:0] a3, b3;
  logic [5:0] p3;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic       start4, sm4, busy4, done4;
  logic [3:0] a4, b4;
  logic [7:0] p4;

  int nChecks;
  int nPass;

  seq_multiplier #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .signed_mode(sm3),
    .a(a3), .b(b3), .busy(busy3), .done(done3), .p(p3)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
  );

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .p(p4)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Launch one WIDTH=8 operation from a negedge where the block is idle or
  // showing done, then follow it until done. Returns at the done negedge.
  task automatic applyStimulus(input string tag, input logic sm,
                               input logic [7:0] x, input logic [7:0] y,
                               input logic [15:0] prevP,
                               input logic [15:0] expP);
    int n;
    start8 = 1'b1;
    sm8    = sm;
    a8     = x;
    b8     = y;
    @(negedge clk);
    start8 = 1'b0;
    checkOutput({tag, " busy"}, 64'(busy8), 64'(1));
    checkOutput({tag, " p held"}, 64'(p8), 64'(prevP));
    n = 0;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " latency"}, 64'(n), 64'(9));
    checkOutput({tag, " p"}, 64'(p8), 64'(expP));
    checkOutput({tag, " busy at done"}, 64'(busy8), 64'(0));
  endtask

  // Launch one WIDTH=4 operation back-to-back and check its product.
  task automatic runOp4(input logic sm, input logic [3:0] x,
                        input logic [3:0] y, input logic [7:0] expP);
    int n;
    start4 = 1'b1;
    sm4    = sm;
    a4     = x;
    b4     = y;
    @(negedge clk);
    start4 = 1'b0;
    a4     = 4'($urandom);
    b4     = 4'($urandom);
    sm4    = 1'($urandom);
    n = 0;
    while (!done4 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("w4 sm%0d %0d*%0d latency", sm, x, y), 64'(n), 64'(5));
    checkOutput($sformatf("w4 sm%0d %0d*%0d p", sm, x, y), 64'(p4), 64'(expP));
  endtask

  // Directed sequence covering every scenario in order.
  initial begin
    int n;
    int busyCnt;
    int doneCnt;
    int sa;
    int sb;
    logic [7:0] refP;

    nChecks = 0;
    nPass   = 0;
    start3 = 0; sm3 = 0; a3 = 0; b3 = 0;
    start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
    start4 = 0; sm4 = 0; a4 = 0; b4 = 0;

    rst = 1'b1;
    #2;
    checkOutput("reset p8", 64'(p8), 64'(0));
    checkOutput("reset busy8", 64'(busy8), 64'(0));
    checkOutput("reset done8", 64'(done8), 64'(0));
    checkOutput("reset p3", 64'(p3), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] WIDTH=3 unsigned 3*7");
    start3 = 1'b1; a3 = 3'd3; b3 = 3'd7;
    @(negedge clk);
    start3 = 1'b0;
    busyCnt = busy3 ? 1 : 0;
    n = 0;
    while (!done3 && n < 10) begin
      @(negedge clk);
      n++;
      if (busy3) busyCnt++;
    end
    checkOutput("w3 latency", 64'(n), 64'(4));
    checkOutput("w3 busy cycles", 64'(busyCnt), 64'(4));
    checkOutput("w3 p", 64'(p3), 64'(21));
    @(negedge clk);
    checkOutput("w3 done pulse", 64'(done3), 64'(0));
    checkOutput("w3 p after", 64'(p3), 64'(21));

    $display("[TB] WIDTH=8 signed corner cases");
    applyStimulus("s -128*-128", 1'b1, 8'h80, 8'h80, 16'h0000, 16'h4000);
    applyStimulus("s -5*7", 1'b1, 8'hFB, 8'h07, 16'h4000, 16'hFFDD);
    applyStimulus("s 127*-1", 1'b1, 8'h7F, 8'hFF, 16'hFFDD, 16'hFF81);

    $display("[TB] WIDTH=8 unsigned cases");
    applyStimulus("u 255*255", 1'b0, 8'hFF, 8'hFF, 16'hFF81, 16'hFE01);
    applyStimulus("u 0*200", 1'b0, 8'h00, 8'hC8, 16'hFE01, 16'h0000);
    @(negedge clk);
    checkOutput("u done pulse", 64'(done8), 64'(0));
    checkOutput("u p stable", 64'(p8), 64'(0));

    $display("[TB] WIDTH=8 start while busy, then back-to-back");
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'd12; b8 = 8'd10;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    start8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
    @(negedge clk);
    start8 = 1'b0;
    n = 4;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ignored start latency", 64'(n), 64'(9));
    checkOutput("ignored start p", 64'(p8), 64'(120));
    applyStimulus("b2b 6*7", 1'b0, 8'd6, 8'd7, 16'd120, 16'd42);
    @(negedge clk);
    checkOutput("b2b single done", 64'(done8), 64'(0));

    $display("[TB] WIDTH=8 asynchronous abort");
    start8 = 1'b1; a8 = 8'd9; b8 = 8'd9;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort p", 64'(p8), 64'(0));
    checkOutput("abort busy", 64'(busy8), 64'(0));
    checkOutput("abort done", 64'(done8), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) doneCnt++;
    end
    checkOutput("abort no done", 64'(doneCnt), 64'(0));
    applyStimulus("after abort 9*9", 1'b0, 8'd9, 8'd9, 16'd0, 16'd81);

    $display("[TB] WIDTH=4 exhaustive sweep");
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          sa = (s == 1 && x >= 8) ? x - 16 : x;
          sb = (s == 1 && y >= 8) ? y - 16 : y;
          refP = 8'(sa * sb);
          runOp4(1'(s), 4'(x), 4'(y), refP);
        end
      end
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
